// File: rtl/zapper_reader.sv
// zapper_reader: light-gun front end for the flash-frame shot protocol.
// Synchronises and debounces the trigger, follows the IDLE->BLACK->WHITE->HELD
// frame sequence, and counts photodiode-lit active pixels to decide hit/miss.
module zapper_reader #(
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter int unsigned LIGHT_MIN        = 64,
  parameter int unsigned DARK_MAX         = 16,
  parameter bit          LIGHT_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger_raw,
  input  logic light_raw,
  input  logic frame_pulse,
  input  logic valid,
  output logic trigger,
  output logic detect,
  output logic shot,
  output logic hit,
  output logic miss,
  output logic busy
);

  // Raw photodiode level that means "no light"
  localparam logic        LIGHT_IDLE = LIGHT_ACTIVE_LOW;
  localparam logic [17:0] DEB_LAST   = 18'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LIT_THR    = 16'(LIGHT_MIN - 1);
  localparam logic [15:0] DARK_LIM   = 16'(DARK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2,
    HELD  = 2'd3
  } state_t;

  state_t      state;
  logic        trig_meta, trig_s;
  logic        light_meta, light_sync;
  logic        light_s;
  logic [17:0] deb_cnt;
  logic        deb_level;
  logic        frame_pulse_d;
  logic        fe;
  logic        frame_fall;
  logic        lit_sample;
  logic [15:0] lit_cnt;
  logic [15:0] dark_cnt;
  logic        void_flag;

  assign light_s    = light_sync ^ LIGHT_ACTIVE_LOW;
  assign fe         = frame_pulse & ~frame_pulse_d;
  assign frame_fall = ~frame_pulse & frame_pulse_d;
  // The fe-cycle sample belongs to the new frame and is dropped
  assign lit_sample = light_s & valid & ~fe;

  // Two-flop synchronisers for the asynchronous gun inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta  <= 1'b0;
      trig_s     <= 1'b0;
      light_meta <= LIGHT_IDLE;
      light_sync <= LIGHT_IDLE;
    end else begin
      trig_meta  <= trigger_raw;
      trig_s     <= trig_meta;
      light_meta <= light_raw;
      light_sync <= light_meta;
    end
  end

  // Debounce: level follows trig_s only after it has differed long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (trig_s != deb_level) begin
      if (deb_cnt == DEB_LAST) begin
        deb_level <= trig_s;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 18'd1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Frame edge tracking; trigger updates only on the frame_pulse fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pulse_d <= 1'b0;
      trigger       <= 1'b0;
    end else begin
      frame_pulse_d <= frame_pulse;
      if (frame_fall) trigger <= deb_level;
    end
  end

  // Lit-pixel counters for the WHITE and BLACK frames, cleared each frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lit_cnt  <= '0;
      dark_cnt <= '0;
    end else if (fe) begin
      lit_cnt  <= '0;
      dark_cnt <= '0;
    end else if (lit_sample) begin
      if (state == WHITE && lit_cnt != '1)  lit_cnt  <= lit_cnt + 16'd1;
      if (state == BLACK && dark_cnt != '1) dark_cnt <= dark_cnt + 16'd1;
    end
  end

  // Shot sequencer with registered pulses, busy, detect and void flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shot      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      busy      <= 1'b0;
      detect    <= 1'b0;
      void_flag <= 1'b0;
    end else begin
      shot <= 1'b0;
      hit  <= 1'b0;
      miss <= 1'b0;
      if (fe) begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state <= BLACK;
              shot  <= 1'b1;
              busy  <= 1'b1;
            end
          end
          BLACK: begin
            state     <= WHITE;
            busy      <= 1'b1;
            void_flag <= (dark_cnt > DARK_LIM);
          end
          WHITE: begin
            state <= HELD;
            busy  <= 1'b0;
            if (detect) hit  <= 1'b1;
            else        miss <= 1'b1;
          end
          HELD: begin
            detect <= 1'b0;
            if (!trigger) begin
              state     <= IDLE;
              void_flag <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == WHITE && lit_sample && lit_cnt >= LIT_THR && !void_flag) begin
        detect <= 1'b1;
      end
    end
  end

endmodule
